// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode instruction handshake: one registered instruction word plus its PC,
// transferred when valid and ready are both high.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] pc;

  modport master (
    output valid,
    output data,
    output pc,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  pc,
    output ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage behind the boot ROM: owns the PC, captures the combinational ROM word into a
// one-entry output register and presents it to decode; supports redirect, pause and wrap halt.
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,

  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data,

  input  logic                  run,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,

  instr_fetch_unit_if.master    instr,
  output logic                  halted
);

  localparam logic StRun  = 1'b0;
  localparam logic StHalt = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] PcOne  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PcLast = '1;

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
  logic                  halted_q, halted_d;

  logic xfer;
  logic load;

  assign xfer = valid_q & instr.ready;
  // The output slot is free if empty or being drained this cycle, giving one per cycle.
  assign load = (state_q == StRun) & run & ~redirect_valid & (~valid_q | instr.ready);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    data_d   = data_q;
    ipc_d    = ipc_q;
    halted_d = halted_q;

    if (redirect_valid) begin
      // Flush wins over everything; a simultaneous transfer still counts as consumed.
      pc_d     = redirect_pc;
      valid_d  = 1'b0;
      state_d  = StRun;
      halted_d = 1'b0;
    end else if (load) begin
      data_d  = rom_data;
      ipc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + PcOne;
      if (pc_q == PcLast) begin
        state_d  = StHalt;
        halted_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ipc_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ipc_q    <= ipc_d;
      halted_q <= halted_d;
    end
  end

  assign rom_address = pc_q;
  assign instr.valid = valid_q;
  assign instr.data  = data_q;
  assign instr.pc    = ipc_q;
  assign halted      = halted_q;

  // A stalled instruction must stay put until taken, flushed or reset.
  stall_stable_a: assert property (@(posedge clk) disable iff (!reset_n)
    valid_q & ~instr.ready & ~redirect_valid |=> valid_q & $stable(data_q) & $stable(ipc_q));

  halt_no_load_a: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == StHalt) |-> ~load);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit against a small behavioural ROM image.
module tb_instr_fetch_unit;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_data;
  logic          run;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_ready;
  logic          halted;

  int tests_run = 0;
  int tests_failed = 0;

  instr_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) instr_bus ();

  instr_fetch_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rom_address   (rom_address),
    .rom_data      (rom_data),
    .run           (run),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr         (instr_bus),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // ROM image: known words at the addresses the plan names, a fixed pattern elsewhere.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    case (a)
      16'h0000: rom_word = 32'h82BF7857;
      16'h0001: rom_word = 32'hFCACD0A9;
      16'h0003: rom_word = 32'hFAFF41FE;
      16'h0007: rom_word = 32'h9F7A8229;
      default:  rom_word = {a, ~a};
    endcase
  endfunction

  assign rom_data        = rom_word(rom_address);
  assign instr_bus.ready = instr_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_instr(input string tag, input logic [AW-1:0] pc,
                              input logic [DW-1:0] word);
    check({tag, ".valid"}, 64'(instr_bus.valid), 64'd1);
    check({tag, ".pc"}, 64'(instr_bus.pc), 64'(pc));
    check({tag, ".data"}, 64'(instr_bus.data), 64'(word));
  endtask

  initial begin
    reset_n        = 1'b0;
    run            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;

    // Reset state
    tick();
    check("rst.valid", 64'(instr_bus.valid), 64'd0);
    check("rst.data", 64'(instr_bus.data), 64'd0);
    check("rst.ipc", 64'(instr_bus.pc), 64'd0);
    check("rst.halted", 64'(halted), 64'd0);
    check("rst.rom_addr", 64'(rom_address), 64'd0);

    // 1. Boot stream, one per cycle
    reset_n = 1'b1;
    tick();
    expect_instr("boot0", 16'd0, 32'h82BF7857);
    tick();
    expect_instr("boot1", 16'd1, 32'hFCACD0A9);
    tick();
    expect_instr("boot2", 16'd2, 32'h0002FFFD);
    tick();
    expect_instr("boot3", 16'd3, 32'hFAFF41FE);
    check("boot.rom_addr", 64'(rom_address), 64'd4);

    // 2. Backpressure at pc 1
    redirect_valid = 1'b1;
    redirect_pc    = 16'd1;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    tick();
    expect_instr("bp.load", 16'd1, 32'hFCACD0A9);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_instr("bp.hold", 16'd1, 32'hFCACD0A9);
      check("bp.rom_addr", 64'(rom_address), 64'd2);
    end
    instr_ready = 1'b1;
    tick();
    expect_instr("bp.rel2", 16'd2, 32'h0002FFFD);
    tick();
    expect_instr("bp.rel3", 16'd3, 32'hFAFF41FE);

    // 3. Redirect while valid
    redirect_valid = 1'b1;
    redirect_pc    = 16'd7;
    tick();
    redirect_valid = 1'b0;
    check("rd.flush", 64'(instr_bus.valid), 64'd0);
    check("rd.rom_addr", 64'(rom_address), 64'd7);
    tick();
    expect_instr("rd.first", 16'd7, 32'h9F7A8229);

    // 4. Wrap and halt
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    check("wrap.rom_addr", 64'(rom_address), 64'hFFFF);
    check("wrap.pre_halt", 64'(halted), 64'd0);
    tick();
    expect_instr("wrap.last", 16'hFFFF, 32'hFFFF0000);
    check("wrap.halted", 64'(halted), 64'd1);
    check("wrap.pc0", 64'(rom_address), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt.valid", 64'(instr_bus.valid), 64'd0);
      check("halt.halted", 64'(halted), 64'd1);
      check("halt.rom_addr", 64'(rom_address), 64'd0);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 16'd0;
    tick();
    redirect_valid = 1'b0;
    check("unhalt.halted", 64'(halted), 64'd0);
    check("unhalt.valid", 64'(instr_bus.valid), 64'd0);
    tick();
    expect_instr("unhalt.first", 16'd0, 32'h82BF7857);

    // 5. Pause for 3 cycles with one instruction pending
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pause.valid", 64'(instr_bus.valid), 64'd0);
      check("pause.rom_addr", 64'(rom_address), 64'd1);
    end
    run = 1'b1;
    tick();
    expect_instr("resume", 16'd1, 32'hFCACD0A9);

    // 6. Asynchronous reset mid-stall
    instr_ready = 1'b0;
    tick();
    expect_instr("stall", 16'd1, 32'hFCACD0A9);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.valid", 64'(instr_bus.valid), 64'd0);
    check("arst.halted", 64'(halted), 64'd0);
    check("arst.rom_addr", 64'(rom_address), 64'd0);
    check("arst.data", 64'(instr_bus.data), 64'd0);
    tick();
    instr_ready = 1'b1;
    reset_n     = 1'b1;
    tick();
    expect_instr("restart0", 16'd0, 32'h82BF7857);
    tick();
    expect_instr("restart1", 16'd1, 32'hFCACD0A9);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
